// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor controller.
// The master drives operands and start; the slave returns status and result.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin_init;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output start, A, B, bin_init,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B, bin_init,
        output busy, done, Diff, Bout
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB-first over WIDTH
// cycles to produce A - B - bin_init, with a start/busy/done handshake.
module serial_sub_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             d;
    logic             borrow_nx;
    logic             last;
    logic [WIDTH-1:0] r_nx;

    assign d         = a_sh[0] ^ b_sh[0] ^ borrow;
    assign borrow_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign r_nx      = {d, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (last)      state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            S_RUN:   bus.busy = 1'b1;
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Result register only loads on the completion edge, so partial sums never leak.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        borrow <= bus.bin_init;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_sh   <= r_nx;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_nx;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        diff_q <= r_nx;
                        bout_q <= borrow_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;

endmodule
